// File: rtl/hazard_dest_tracker_pkg.sv
// Shared types and constants for the hazard / destination-tag tracker.
package hazard_dest_tracker_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    HOLD     = 2'd2
  } hazState_t;

  // Forwarding-unit select encodings for a source operand
  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_MEMWB   = 2'd1;
  localparam logic [1:0] FWD_EXMEM   = 2'd2;

  // Reference select for a source tag: $0 never forwards, EX/MEM beats MEM/WB
  function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] src,
                                        input logic [REG_W-1:0] dfw,
                                        input logic [REG_W-1:0] mfw);
    logic [1:0] sel;
    if (src == {REG_W{1'b0}}) begin
      sel = FWD_REGFILE;
    end else if (src == dfw) begin
      sel = FWD_EXMEM;
    end else if (src == mfw) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_REGFILE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_dest_tracker_stage_reg.sv
// Pipeline tag register with hold (en=0) and NOP-insert (bubble=1) controls.
module hazard_stage_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold when disabled; a bubble loads an all-zero tag set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= bubble ? {W{1'b0}} : d;
    end
  end

endmodule

// File: rtl/hazard_dest_tracker.sv
// Destination-tag pipeline, load-use stall and memory-wait freeze control.
// Optional stall counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_dest_tracker #(
  parameter int REG_W = hazard_dest_tracker_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  input  logic             mem_wait,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic [REG_W-1:0] RegDest_Dfw,
  output logic [REG_W-1:0] RegDest_Mfw,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt
);
  import hazard_dest_tracker_pkg::*;

  localparam int EX_W = 3 * REG_W + 2;

  logic [EX_W-1:0]  exQ;
  logic [REG_W:0]   memQ;
  logic [REG_W:0]   wbQ;
  logic [REG_W-1:0] exDest;
  logic             exWe;
  logic             exMr;
  logic             luHazard;
  logic             stageEn;
  logic             exBubble;
  hazState_t        state;

  assign ex_rs  = exQ[EX_W-1 -: REG_W];
  assign ex_rt  = exQ[2*REG_W+1 -: REG_W];
  assign exDest = exQ[REG_W+1 -: REG_W];
  assign exWe   = exQ[1];
  assign exMr   = exQ[0];

  // Load in EX whose result the ID instruction needs before it exists
  always_comb begin
    luHazard = exMr & exWe & (exDest != {REG_W{1'b0}})
             & ((exDest == id_rs) | (exDest == id_rt));
  end

  // Cycle controls: memory wait freezes everything, then load-use, then flush
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if (mem_wait) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b0;
    end else if (luHazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (flush) begin
      id_ex_bubble = 1'b1;
    end else begin
      id_ex_bubble = 1'b0;
    end
  end

  assign stageEn  = ~mem_wait;
  assign exBubble = luHazard | flush;

  hazard_stage_reg #(.W(EX_W)) exStage (
    .clk    (clk),
    .reset  (reset),
    .en     (stageEn),
    .bubble (exBubble),
    .d      ({id_rs, id_rt, id_dest, id_reg_write, id_mem_read}),
    .q      (exQ)
  );

  hazard_stage_reg #(.W(REG_W + 1)) memStage (
    .clk    (clk),
    .reset  (reset),
    .en     (stageEn),
    .bubble (1'b0),
    .d      ({exDest, exWe}),
    .q      (memQ)
  );

  hazard_stage_reg #(.W(REG_W + 1)) wbStage (
    .clk    (clk),
    .reset  (reset),
    .en     (stageEn),
    .bubble (1'b0),
    .d      (memQ),
    .q      (wbQ)
  );

  assign RegDest_Dfw = memQ[0] ? memQ[REG_W:1] : {REG_W{1'b0}};
  assign RegDest_Mfw = wbQ[0]  ? wbQ[REG_W:1]  : {REG_W{1'b0}};

  // Stall-sequencing state: one LU_STALL cycle per hazard, HOLD during memory wait
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:      state <= mem_wait ? HOLD : (luHazard ? LU_STALL : RUN);
        LU_STALL: state <= mem_wait ? HOLD : RUN;
        HOLD:     state <= mem_wait ? HOLD : RUN;
        default:  state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stallCnt;

  // Saturating count of cycles actually lost to load-use stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= {CNT_W{1'b0}};
    end else if (luHazard & ~mem_wait & (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stallCnt;
`else
  assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_dest_tracker.sv
// Scoreboard bench for hazard_dest_tracker: expectations queued at drive time.
module tb_hazard_dest_tracker;
  import hazard_dest_tracker_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_reg_write, id_mem_read, flush, mem_wait;
  logic [4:0]  ex_rs, ex_rt, RegDest_Dfw, RegDest_Mfw;
  logic        pc_write, if_id_write, id_ex_bubble;
  logic [15:0] stall_cnt;

  int checkCnt = 0;
  int errCnt   = 0;

  typedef struct packed { logic pc; logic ifid; logic bub; } ctlExp_t;
  typedef struct packed {
    logic [4:0] rs; logic [4:0] rt; logic [4:0] dfw; logic [4:0] mfw; logic [15:0] cnt;
  } tagExp_t;

  ctlExp_t ctlQ[$];
  tagExp_t tagQ[$];

  // Reference pipeline state
  logic [4:0]  mExRs, mExRt, mExDest, mMemDest, mWbDest;
  logic        mExWe, mExMr, mMemWe, mWbWe;
  logic [15:0] mCnt;

  hazard_dest_tracker dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .mem_wait(mem_wait), .ex_rs(ex_rs), .ex_rt(ex_rt), .RegDest_Dfw(RegDest_Dfw),
    .RegDest_Mfw(RegDest_Mfw), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_bubble(id_ex_bubble), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelClear();
    mExRs = 5'd0; mExRt = 5'd0; mExDest = 5'd0; mExWe = 1'b0; mExMr = 1'b0;
    mMemDest = 5'd0; mMemWe = 1'b0; mWbDest = 5'd0; mWbWe = 1'b0; mCnt = 16'd0;
  endtask

  // One pipeline cycle: drive ID inputs, queue expectations, check controls then tags
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                      input logic we, input logic mr, input logic fl, input logic mw);
    logic    lu;
    ctlExp_t c;
    tagExp_t t;
    ctlExp_t cGot;
    tagExp_t tGot;
    id_rs = rs; id_rt = rt; id_dest = dest; id_reg_write = we; id_mem_read = mr;
    flush = fl; mem_wait = mw;
    lu = mExMr && mExWe && (mExDest != 5'd0) && (mExDest == rs || mExDest == rt);
    if (mw)      c = '{pc: 1'b0, ifid: 1'b0, bub: 1'b0};
    else if (lu) c = '{pc: 1'b0, ifid: 1'b0, bub: 1'b1};
    else if (fl) c = '{pc: 1'b1, ifid: 1'b1, bub: 1'b1};
    else         c = '{pc: 1'b1, ifid: 1'b1, bub: 1'b0};
    ctlQ.push_back(c);
    if (!mw) begin
      if (lu && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
      mWbDest = mMemDest; mWbWe = mMemWe;
      mMemDest = mExDest; mMemWe = mExWe;
      if (lu || fl) begin
        mExRs = 5'd0; mExRt = 5'd0; mExDest = 5'd0; mExWe = 1'b0; mExMr = 1'b0;
      end else begin
        mExRs = rs; mExRt = rt; mExDest = dest; mExWe = we; mExMr = mr;
      end
    end
    t.rs  = mExRs;
    t.rt  = mExRt;
    t.dfw = mMemWe ? mMemDest : 5'd0;
    t.mfw = mWbWe ? mWbDest : 5'd0;
`ifdef HAZARD_STALL_CNT_EN
    t.cnt = mCnt;
`else
    t.cnt = 16'd0;
`endif
    tagQ.push_back(t);
    #1;
    cGot = ctlQ.pop_front();
    checkVal("pc_write", 32'(pc_write), 32'(cGot.pc));
    checkVal("if_id_write", 32'(if_id_write), 32'(cGot.ifid));
    checkVal("id_ex_bubble", 32'(id_ex_bubble), 32'(cGot.bub));
    @(posedge clk);
    #1;
    tGot = tagQ.pop_front();
    checkVal("ex_rs", 32'(ex_rs), 32'(tGot.rs));
    checkVal("ex_rt", 32'(ex_rt), 32'(tGot.rt));
    checkVal("RegDest_Dfw", 32'(RegDest_Dfw), 32'(tGot.dfw));
    checkVal("RegDest_Mfw", 32'(RegDest_Mfw), 32'(tGot.mfw));
    checkVal("stall_cnt", 32'(stall_cnt), 32'(tGot.cnt));
  endtask

  task automatic idle();
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    id_rs = 5'd0; id_rt = 5'd0; id_dest = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    flush = 1'b0; mem_wait = 1'b0;
    modelClear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkVal("rstPc", 32'(pc_write), 32'd1);
    checkVal("rstIfId", 32'(if_id_write), 32'd1);
    checkVal("rstBubble", 32'(id_ex_bubble), 32'd0);
    checkVal("rstDfw", 32'(RegDest_Dfw), 32'd0);
    checkVal("rstState", 32'(dut.state), 32'(RUN));

    // lw $8 then add $9,$8,$3: one stall, then Dfw=0 and Mfw=8
    step(5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step(5'd8, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("luBubbleDfw", 32'(RegDest_Dfw), 32'd8);
    step(5'd8, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("luDfwAfter", 32'(RegDest_Dfw), 32'd0);
    checkVal("luMfwAfter", 32'(RegDest_Mfw), 32'd8);
    checkVal("luFwdSel", 32'(fwdSel(5'd8, RegDest_Dfw, RegDest_Mfw)), 32'(FWD_MEMWB));
    idle(); idle();

    // lw $0 then add using $0: no stall, Dfw stays 0
    step(5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("zeroDfw", 32'(RegDest_Dfw), 32'd0);
    idle(); idle();

    // add $5 then sub using $5: Dfw=5 then Mfw=5
    step(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("aluDfw", 32'(RegDest_Dfw), 32'd5);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("aluMfw", 32'(RegDest_Mfw), 32'd5);
    idle(); idle();

    // mem_wait for 3 cycles while a load-use is pending
    step(5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(5'd10, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
      checkVal("waitFrozenRs", 32'(ex_rs), 32'd1);
    end
    step(5'd10, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd10, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("waitResumeRs", 32'(ex_rs), 32'd10);
    idle(); idle();

    // flush together with load-use: lu wins, flush honoured next cycle
    step(5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    step(5'd12, 5'd12, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0);
    step(5'd12, 5'd12, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(); idle();

    // Randomised traffic over a small register range to provoke hazards
    for (int i = 0; i < 60; i++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
    end
    idle(); idle();

    // Reset asserted mid-stall with live tags
    step(5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step(5'd8, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("preRstDfw", 32'(RegDest_Dfw), 32'd8);
    checkVal("preRstState", 32'(dut.state), 32'(LU_STALL));
    id_rs = 5'd0; id_rt = 5'd0; id_dest = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    #1 reset = 1'b1;
    #1;
    checkVal("midRstDfw", 32'(RegDest_Dfw), 32'd0);
    checkVal("midRstMfw", 32'(RegDest_Mfw), 32'd0);
    checkVal("midRstRs", 32'(ex_rs), 32'd0);
    checkVal("midRstRt", 32'(ex_rt), 32'd0);
    checkVal("midRstPc", 32'(pc_write), 32'd1);
    checkVal("midRstState", 32'(dut.state), 32'(RUN));
    checkVal("midRstCnt", 32'(stall_cnt), 32'd0);
    reset = 1'b0;
    modelClear();
    @(posedge clk);
    #1;
    idle();
    step(5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/hazard_dest_tracker.md
Name: hazard_dest_tracker

Overview:
Producer side of the forwarding interface. Carries destination-register tags, write-enable and load flags down the ID/EX, EX/MEM and MEM/WB stages. Drives the EX-stage source tags and the EX/MEM and MEM/WB destination tags consumed by the forwarding unit. Detects load-use hazards forwarding cannot cover and generates stall and bubble controls; also handles branch flush and external memory-wait freeze.

Parameters:
REG_W, 5, register-index width
CNT_W, 16, width of the optional stall counter

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
id_rs  in  REG_W  rs field of instruction in ID
id_rt  in  REG_W  rt field of instruction in ID
id_dest  in  REG_W  resolved write register in ID (rt/rd/31 mux already applied)
id_reg_write  in  1  ID instruction writes the register file
id_mem_read  in  1  ID instruction is a load
flush  in  1  branch/jump taken; kill the instruction in ID
mem_wait  in  1  data memory not ready; freeze whole pipeline
ex_rs  out  REG_W  rs tag of EX instruction (forwarding unit rs_current)
ex_rt  out  REG_W  rt tag of EX instruction (forwarding unit rt_current)
RegDest_Dfw  out  REG_W  EX/MEM destination, 0 when no write
RegDest_Mfw  out  REG_W  MEM/WB destination, 0 when no write
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
id_ex_bubble  out  1  ID/EX loads a NOP this cycle
stall_cnt  out  CNT_W  load-use stall cycles (only with feature)

Behaviour:
- Stage registers: EX {rs,rt,dest,we,mr}, MEM {dest,we}, WB {dest,we}. Reset (async): all cleared to 0.
- RegDest_Dfw = mem_we ? mem_dest : 0. RegDest_Mfw = wb_we ? wb_dest : 0. ex_rs/ex_rt come straight from the EX registers. All are registered values with no combinational path from inputs.
- Load-use hazard (combinational): lu = ex_mr & ex_we & (ex_dest != 0) & ((ex_dest == id_rs) | (ex_dest == id_rt)).
- FSM states: RUN, LU_STALL, HOLD. Reset state is RUN.
- RUN:
  - mem_wait=1 -> HOLD.
  - Otherwise, lu=1 -> LU_STALL.
  - Otherwise stays in RUN.
- LU_STALL:
  - Lasts exactly one cycle.
  - Goes to HOLD if mem_wait=1, else RUN.
  - The load is now in MEM, so lu falls naturally.
- HOLD: stays while mem_wait=1. On mem_wait=0, returns to RUN and re-evaluates lu.
- Cycle controls, in priority order:
  1. mem_wait=1 (any state): pc_write=0, if_id_write=0, id_ex_bubble=0. All stage registers hold.
  2. lu=1: pc_write=0, if_id_write=0, id_ex_bubble=1. EX loads all-zero. MEM<-EX and WB<-MEM advance.
  3. flush=1: pc_write=1, if_id_write=1, id_ex_bubble=1. EX loads zero.
  4. Otherwise: all advance. EX <- {id_rs, id_rt, id_dest, id_reg_write, id_mem_read}. pc_write=if_id_write=1, id_ex_bubble=0.
- flush and lu together: lu wins; flush is held by the branch unit and honoured next cycle.
- Reset outputs: pc_write=1, if_id_write=1, id_ex_bubble=0, all tags 0.
- A write to $0 (dest=0) never forwards and never stalls.
- Reset asserted mid-stall: FSM forced to RUN and all tags cleared immediately.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: stall_cnt counts cycles with lu=1 and mem_wait=0. It saturates at all-ones and is cleared by reset.
- Undefined: the counter register is absent and stall_cnt is tied to 0.

Decomposition:
- Shared package:
  - REG_W constant.
  - FSM state typedef: RUN=2'd0, LU_STALL=2'd1, HOLD=2'd2.
  - Forward-select encodings: 0 = regfile, 1 = MEM/WB, 2 = EX/MEM.
- One natural sub-module, hazard_stage_reg: an enable/bubble-capable tag register, instantiated for the EX, MEM and WB stages.

Test Plan:
- Reset mid-run with nonzero tags -> RegDest_Dfw=RegDest_Mfw=ex_rs=ex_rt=0, pc_write=1, FSM in RUN on the same edge.
- lw $8 then add $9,$8,$3 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1. Next cycle RegDest_Dfw=0 (bubble) and RegDest_Mfw=8, so the forwarding unit selects 1.
- lw $0 then add using $0 -> no stall; RegDest_Dfw=0 when the load reaches MEM.
- add $5 then sub using $5 -> no stall, RegDest_Dfw=5 for one cycle, then RegDest_Mfw=5.
- mem_wait high for 3 cycles during lu -> all tags frozen for 3 cycles. Then exactly one LU_STALL cycle and resume; stall_cnt=1 if the feature is enabled.
- flush together with lu -> bubble inserted, pc_write=0. flush next cycle -> id_ex_bubble=1, pc_write=1.
